// File: rtl/fp8_pkg.sv
// Float8 format constants shared by the int-to-float8 pipeline and its lanes.
// e4m3: 4-bit exponent, 3-bit mantissa, bias 7, no infinity, 0x7F is NaN.
// e5m2: 5-bit exponent, 2-bit mantissa, bias 15, 0x7C is infinity.
package fp8_pkg;

  typedef enum logic {
    FMT_E4M3 = 1'b0,
    FMT_E5M2 = 1'b1
  } fmt_e;

  // e4m3
  localparam int         E4M3_EXP_W      = 4;
  localparam int         E4M3_MANT_W     = 3;
  localparam int         E4M3_BIAS       = 7;
  localparam int         E4M3_MAX_FINITE = 448;   // 1.110b * 2^8
  localparam int         E4M3_EMAX       = 8;     // unbiased exponent of max finite
  localparam int         E4M3_MAX_MANT   = 6;     // mantissa of max finite at EMAX
  localparam logic [7:0] E4M3_MAX_CODE   = 8'h7E;
  localparam logic [7:0] E4M3_NAN_CODE   = 8'h7F;

  // e5m2
  localparam int         E5M2_EXP_W      = 5;
  localparam int         E5M2_MANT_W     = 2;
  localparam int         E5M2_BIAS       = 15;
  localparam int         E5M2_MAX_FINITE = 57344; // 1.11b * 2^15
  localparam int         E5M2_EMAX       = 15;
  localparam int         E5M2_MAX_MANT   = 3;
  localparam logic [7:0] E5M2_MAX_CODE   = 8'h7B;
  localparam logic [7:0] E5M2_INF_CODE   = 8'h7C;

endpackage

// File: rtl/int_to_float8_lane.sv
// One combinational conversion lane: sign/magnitude -> float8 code.
// Normalises the magnitude, rounds to nearest-even and flags overflow.
// Build option I2F8_SAT_EN: overflowing lanes saturate to the max finite
// code; otherwise they become NaN (e4m3) or infinity (e5m2).
module int_to_float8_lane
  import fp8_pkg::*;
#(
  parameter int FMT   = 0,
  parameter int INT_W = 4
) (
  input  logic             sign,
  input  logic [INT_W-1:0] mag,
  output logic [7:0]       code,
  output logic             ovf
);

  localparam fmt_e FMT_SEL  = (FMT == 1) ? FMT_E5M2 : FMT_E4M3;
  localparam bit   IS_E5M2  = (FMT_SEL == FMT_E5M2);
  localparam int   EW       = IS_E5M2 ? E5M2_EXP_W    : E4M3_EXP_W;
  localparam int   M        = IS_E5M2 ? E5M2_MANT_W   : E4M3_MANT_W;
  localparam int   BIAS     = IS_E5M2 ? E5M2_BIAS     : E4M3_BIAS;
  localparam int   EMAX     = IS_E5M2 ? E5M2_EMAX     : E4M3_EMAX;
  localparam int   MAX_MANT = IS_E5M2 ? E5M2_MAX_MANT : E4M3_MAX_MANT;
`ifdef I2F8_SAT_EN
  localparam logic [7:0] OVF_CODE = IS_E5M2 ? E5M2_MAX_CODE : E4M3_MAX_CODE;
`else
  localparam logic [7:0] OVF_CODE = IS_E5M2 ? E5M2_INF_CODE : E4M3_NAN_CODE;
`endif
  // Headroom below the leading one so guard and sticky always exist,
  // even for narrow inputs where p < M.
  localparam int W   = INT_W + 4;
  localparam int MP1 = M + 1;

  logic [4:0]    p;
  logic [4:0]    shamt;
  logic [W-1:0]  norm;
  logic          nonzero;
  logic [M-1:0]  mant;
  logic          guard;
  logic          sticky;
  logic          round_up;
  logic [M:0]    mant_r;
  logic [5:0]    e_unb;
  logic [EW-1:0] exp_f;

  // Leading-one detect, normalise, round-to-nearest-even, encode.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned (which would infer a latch).
    p = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (mag[i]) p = 5'(i);
    end
    shamt    = 5'(W - 1) - p;
    norm     = W'(mag) << shamt;
    nonzero  = norm[W-1];
    mant     = norm[W-2 -: M];
    guard    = norm[W-2-M];
    sticky   = |norm[W-3-M:0];
    round_up = guard & (sticky | mant[0]);
    // A mantissa carry leaves mant_r[M-1:0] at zero and bumps the exponent.
    mant_r   = {1'b0, mant} + MP1'(round_up);
    e_unb    = {1'b0, p} + 6'(mant_r[M]);
    exp_f    = EW'(e_unb + 6'(BIAS));
    ovf      = nonzero &&
               ((e_unb > 6'(EMAX)) ||
                ((e_unb == 6'(EMAX)) && (mant_r[M-1:0] > M'(MAX_MANT))));
    code     = '0;
    if (ovf)          code = {sign, OVF_CODE[6:0]};
    else if (nonzero) code = {sign, exp_f, mant_r[M-1:0]};
  end

endmodule

// File: rtl/int_to_float8_pipe.sv
// Two-stage, LANES-wide pipeline converting biased unsigned integers to
// float8 (e4m3 or e5m2) with valid/ready handshakes on both sides.
// Stage 1 holds sign/magnitude, stage 2 holds the rounded codes.
// Build option I2F8_SAT_EN selects saturation on overflow (see lane).
module int_to_float8_pipe
  import fp8_pkg::*;
#(
  parameter int FMT     = 0,
  parameter int INT_W   = 4,
  parameter int IN_BIAS = 7,
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*INT_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*8-1:0]     out_data,
  output logic [LANES-1:0]       out_ovf
);

  localparam int IW1 = INT_W + 1;

  logic [LANES-1:0]       in_sign;
  logic [LANES*INT_W-1:0] in_mag;
  logic [LANES*8-1:0]     lane_code;
  logic [LANES-1:0]       lane_ovf;

  logic                   s1_valid_q, s1_valid_d;
  logic [LANES-1:0]       s1_sign_q, s1_sign_d;
  logic [LANES*INT_W-1:0] s1_mag_q, s1_mag_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [LANES*8-1:0]     out_data_q, out_data_d;
  logic [LANES-1:0]       out_ovf_q, out_ovf_d;

  logic s2_ready;
  logic s1_advance;
  logic in_fire;

  // Per lane: bias removal into sign/magnitude, and the conversion lane
  // fed from the stage-1 register.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [INT_W:0] v;
    assign v = {1'b0, in_data[k*INT_W +: INT_W]} - IW1'(IN_BIAS);
    assign in_sign[k] = v[INT_W];
    assign in_mag[k*INT_W +: INT_W] = v[INT_W] ? (~v[INT_W-1:0] + 1'b1)
                                               : v[INT_W-1:0];

    int_to_float8_lane #(
      .FMT   (FMT),
      .INT_W (INT_W)
    ) u_lane (
      .sign (s1_sign_q[k]),
      .mag  (s1_mag_q[k*INT_W +: INT_W]),
      .code (lane_code[k*8 +: 8]),
      .ovf  (lane_ovf[k])
    );
  end

  assign s2_ready   = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;

  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;

  // Stage 1: load a new beat whenever the stage is free or draining.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_sign_d = in_sign;
      s1_mag_d  = in_mag;
    end
  end

  // Stage 2: take stage 1's beat when empty or being emptied; hold otherwise.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s1_advance) begin
      out_data_d = lane_code;
      out_ovf_d  = lane_ovf;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values; data flops are cleared too so a dropped beat can
    // never leak onto out_data after reset.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= '0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_int_to_float8_pipe.sv
// Directed bench for int_to_float8_pipe: default e4m3 4-lane instance plus
// three 2-lane instances (INT_W=8, INT_W=16, e5m2) sharing clock and reset.
module tb_int_to_float8_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Default instance: FMT=0, INT_W=4, IN_BIAS=7, LANES=4
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [31:0] out_data;
  logic [3:0]  out_ovf;

  int_to_float8_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  // INT_W=8, IN_BIAS=0
  logic        a_in_valid, a_in_ready, a_out_valid;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_out_ovf;

  int_to_float8_pipe #(.FMT(0), .INT_W(8), .IN_BIAS(0), .LANES(2)) dut_w8 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(1'b1),
    .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  // INT_W=16, IN_BIAS=0, e4m3
  logic        b_in_valid, b_in_ready, b_out_valid;
  logic [31:0] b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ovf;

  int_to_float8_pipe #(.FMT(0), .INT_W(16), .IN_BIAS(0), .LANES(2)) dut_w16 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  // e5m2, INT_W=4, IN_BIAS=7
  logic        c_in_valid, c_in_ready, c_out_valid;
  logic [7:0]  c_in_data;
  logic [15:0] c_out_data;
  logic [1:0]  c_out_ovf;

  int_to_float8_pipe #(.FMT(1), .INT_W(4), .IN_BIAS(7), .LANES(2)) dut_f1 (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(1'b1),
    .out_data(c_out_data), .out_ovf(c_out_ovf)
  );

  // Hand-computed vectors (lane 0 in the low bits).
  // A: {F,8,7,0} -> v {8,1,0,-7} -> {50,38,00,CE}
  localparam logic [15:0] IN_A  = 16'hF870;
  localparam logic [31:0] EXP_A = 32'h5038_00CE;
  // B: {A,1,6,9} -> v {3,-6,-1,2} -> {44,CC,B8,40}
  localparam logic [15:0] IN_B  = 16'hA169;
  localparam logic [31:0] EXP_B = 32'h44CC_B840;
  // w8: lane1=19 (round up), lane0=17 (tie to even)
  localparam logic [15:0] IN_W8  = {8'd19, 8'd17};
  localparam logic [15:0] EXP_W8 = 16'h5A58;
  // w16: lane1=500 (overflow), lane0=448 (max finite)
`ifdef I2F8_SAT_EN
  localparam logic [15:0] EXP_W16 = 16'h7E7E;
`else
  localparam logic [15:0] EXP_W16 = 16'h7F7E;
`endif
  localparam logic [31:0] IN_W16 = {16'd500, 16'd448};
  // e5m2: lane1=0x0 (v=-7), lane0=0xF (v=8)
  localparam logic [7:0]  IN_F1  = 8'h0F;
  localparam logic [15:0] EXP_F1 = 16'hC748;

  logic [15:0] bp_beats [2];
  logic [31:0] bp_exp   [2];
  int acc;
  int got_n;
  int stale;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bp_beats[0] = IN_A;  bp_beats[1] = IN_B;
    bp_exp[0]   = EXP_A; bp_exp[1]   = EXP_B;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    a_in_valid = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_data = '0;
    c_in_valid = 1'b0; c_in_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_ovf", out_ovf, 4'h0);
    rst = 1'b0;

    // Beat A then B back to back; aux instances get one beat each.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = IN_A;
    a_in_valid = 1'b1; a_in_data = IN_W8;
    b_in_valid = 1'b1; b_in_data = IN_W16;
    c_in_valid = 1'b1; c_in_data = IN_F1;
    @(negedge clk);
    check("first_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_data = IN_B;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    @(negedge clk);
    check("latency_not_yet", out_valid, 1'b0);
    check("w8_not_yet", a_out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("a_out_valid", out_valid, 1'b1);
    check("a_out_data", out_data, EXP_A);
    check("a_out_ovf", out_ovf, 4'h0);
    check("w8_valid", a_out_valid, 1'b1);
    check("w8_data", a_out_data, EXP_W8);
    check("w8_ovf", a_out_ovf, 2'b00);
    check("w16_valid", b_out_valid, 1'b1);
    check("w16_data", b_out_data, EXP_W16);
    check("w16_ovf", b_out_ovf, 2'b10);
    check("e5m2_valid", c_out_valid, 1'b1);
    check("e5m2_data", c_out_data, EXP_F1);
    check("e5m2_ovf", c_out_ovf, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_out_valid", out_valid, 1'b1);
    check("b_out_data", out_data, EXP_B);
    check("w8_drained", a_out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drained", out_valid, 1'b0);

    // Backpressure: out_ready low for 5 cycles while streaming.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_data = (acc < 2) ? bp_beats[acc] : 16'h7777;
      @(negedge clk);
      if (in_ready) acc++;
      if (out_valid) check("bp_stable", out_data, EXP_A);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", acc, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_hold_data", out_data, EXP_A);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; got_n = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got_n < 2) check("bp_order", out_data, bp_exp[got_n]);
        got_n++;
      end
      @(posedge clk); #1;
    end
    check("bp_emitted", got_n, 2);

    // Reset with two beats in flight.
    in_valid = 1'b1; in_data = IN_A;
    @(posedge clk); #1;
    in_data = IN_B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_drop_valid", out_valid, 1'b0);
    check("rst_drop_data", out_data, 32'h0);
    check("rst_drop_ovf", out_ovf, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_beat", stale, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_to_float8_pipe.md
INT_TO_FLOAT8_PIPE -- requirements
Module: int_to_float8_pipe

Interface
REQ-001 SHALL have parameter FMT, default 0: output format; 0 = e4m3 (bias 7, 3-bit mantissa), 1 = e5m2 (bias 15, 2-bit mantissa).
REQ-002 SHALL have parameter INT_W, default 4: width of each unsigned input lane, legal range 2..16.
REQ-003 SHALL have parameter IN_BIAS, default 7: bias subtracted from each input, legal range 0..2^INT_W-1.
REQ-004 SHALL have parameter LANES, default 4: number of parallel conversion lanes, legal range 1..16.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, LANES*INT_W bits: lane k at bits [k*INT_W +: INT_W].
REQ-010 SHALL have port out_valid, output, 1 bit: output beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port out_data, output, LANES*8 bits: lane k float8 code at bits [k*8 +: 8].
REQ-013 SHALL have port out_ovf, output, LANES bits: per-lane flag, set when the rounded magnitude exceeds the max finite value.

Function
REQ-014 SHALL, per lane, compute v = in - IN_BIAS as a signed (INT_W+1)-bit value; sign = (v<0); mag = |v|.
REQ-015 SHALL encode v = 0 as 0x00, sign bit clear.
REQ-016 SHALL, for mag != 0, set exponent field = p + format bias, where p is the leading-one index of mag; mantissa = the next M bits below the leading one (M = 3 or 2), zero-filled when p < M.
REQ-017 SHALL round discarded bits to nearest, ties to even; a mantissa carry SHALL increment the exponent and clear the mantissa.
REQ-018 SHALL treat max finite as 448 (code 0x7E) for e4m3 and 57344 (code 0x7B) for e5m2; out_ovf[k] = 1 only when the rounded mag exceeds it.
REQ-019 SHALL be a 2-stage pipeline: stage 1 registers sign/mag; stage 2 registers the normalised, rounded code. Latency is 2 cycles with out_ready held high; throughput is 1 beat/cycle.
REQ-020 SHALL transfer a beat on in_valid & in_ready, and on out_valid & out_ready.
REQ-021 SHALL advance a stage when it is empty or the stage after it advances the same cycle; in_ready = !s1_valid | s1_advance (combinational from out_ready is allowed).
REQ-022 SHALL hold out_valid, out_data and out_ovf stable while out_valid=1 and out_ready=0.
REQ-023 SHALL accept and emit in the same cycle when the pipeline is full and out_ready=1, with no bubble.

Reset
REQ-024 SHALL, on rst assertion and independent of clk, clear both stage valid bits, out_data, out_ovf and stage-1 data to 0.
REQ-025 SHALL drop in-flight beats when reset asserts mid-stream; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-026 SHALL, with I2F8_SAT_EN defined, saturate overflowing lanes to sign | max finite code (e4m3 0x7E, e5m2 0x7B).
REQ-027 SHALL, without I2F8_SAT_EN, drive overflowing lanes to sign | 0x7F (e4m3 NaN) or sign | 0x7C (e5m2 infinity).
REQ-028 SHALL assert out_ovf in both builds.

Structure
REQ-029 SHALL place the format constants (exponent width, mantissa width, bias, max-finite, NaN and infinity codes, FMT enum) in shared package fp8_pkg.
REQ-030 SHALL implement the per-lane normalise/round/saturate logic in combinational sub-module int_to_float8_lane, instantiated LANES times; pipeline registers and handshake live in the top module.

Verification
REQ-031 SHALL cover, at defaults, lanes {0x0, 0x7, 0x8, 0xF} -> out_data lanes {0xCE, 0x00, 0x38, 0x50}, out_ovf = 0, out_valid 2 cycles after the input transfer.
REQ-032 SHALL cover, with INT_W=8, IN_BIAS=0, inputs 17 -> 0x58 (tie to even) and 19 -> 0x5A (round up).
REQ-033 SHALL cover, with INT_W=16, IN_BIAS=0, FMT=0, input 500 -> 0x7E with ovf=1 when I2F8_SAT_EN is defined, and 0x7F with ovf=1 when it is not; input 448 -> 0x7E with ovf=0.
REQ-034 SHALL cover, with FMT=1 and defaults otherwise, input 0xF -> 0x48 and input 0x0 -> 0xC7.
REQ-035 SHALL cover backpressure: with out_ready=0 for 5 cycles and in_valid=1 streaming, exactly 2 beats are accepted, in_ready=0 afterward, and out_data stays stable; releasing out_ready emits the beats in order with no loss.
REQ-036 SHALL cover reset asserted with 2 beats in flight: out_valid drops immediately and no stale beat appears after release.
